// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit:
// FSM states, opcodes, ALU selects and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic legal_op(
    input logic [6:0] op
  );
    return (op == OP_LOAD)  || (op == OP_STORE) ||
           (op == OP_RTYPE) || (op == OP_ITYPE) ||
           (op == OP_BEQ)   || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7 to ALU select; subtract only for
// R-type, since I-type bit 30 belongs to the immediate.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [2:0] alu_sel
);

  always_comb begin
    alu_sel = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (is_rtype && funct7_5) alu_sel = ALU_SUB;
        else                      alu_sel = ALU_ADD;
      end
      3'b010:  alu_sel = ALU_SLT;
      3'b110:  alu_sel = ALU_OR;
      3'b111:  alu_sel = ALU_AND;
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: Moore outputs per
// state, with the branch PC strobe qualified by zero.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_sel,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       pc_wr, ir_wr, mem_wr, reg_wr;
  logic [2:0] dec_sel;

  alu_decoder u_alu_dec (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .is_rtype (opcode == OP_RTYPE),
    .alu_sel  (dec_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    adr_src    = ADR_PC;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_sel    = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        adr_src    = ADR_PC;
        ir_wr      = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_sel    = ALU_ADD;
        result_src = RES_ALU;
        pc_wr      = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        alu_sel   = ALU_ADD;
        case (opcode)
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECR;
          OP_ITYPE: state_d = S_EXECI;
          OP_BEQ:   state_d = S_BEQ;
          OP_JAL:   state_d = S_JAL;
          default:  state_d = S_FETCH;
        endcase
        if (!legal_op(opcode)) illegal_d = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_sel   = ALU_ADD;
        if (opcode == OP_STORE) begin
          imm_src = IMM_S;
          state_d = S_MEMWRITE;
        end else begin
          imm_src = IMM_I;
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = ADR_ALUOUT;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_wr     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = ADR_ALUOUT;
        mem_wr     = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_sel   = dec_sel;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_sel   = dec_sel;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_wr     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_sel    = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_wr      = zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_sel    = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_J;
        pc_wr      = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset kills every write strobe in the same cycle.
  assign pc_write   = pc_wr  & ~rst;
  assign ir_write   = ir_wr  & ~rst;
  assign mem_write  = mem_wr & ~rst;
  assign reg_write  = reg_wr & ~rst;
  assign illegal_op = illegal_d;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller:
// per-cycle control words compared against hand values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write, ir_write, mem_write, reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_sel;
  logic       illegal_op;
  logic [15:0] ctl;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_sel    (alu_sel),
    .illegal_op (illegal_op)
  );

  // {pc,ir,mem,reg,adr,srcA,srcB,res,imm,alu}
  assign ctl = {pc_write, ir_write, mem_write,
                reg_write, adr_src, alu_src_a,
                alu_src_b, result_src, imm_src,
                alu_sel};

  localparam logic [15:0] E_FETCH =
    {4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000};
  localparam logic [15:0] E_FETCH_RST =
    {4'b0000, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000};
  localparam logic [15:0] E_DECODE =
    {4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000};
  localparam logic [15:0] E_MEMADR_L =
    {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MEMADR_S =
    {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000};
  localparam logic [15:0] E_MEMREAD =
    {4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MEMWRITE =
    {4'b0010, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MEMWB =
    {4'b0001, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000};
  localparam logic [15:0] E_ALUWB =
    {4'b0001, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_JAL =
    {4'b1000, 1'b0, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000};

  function automatic logic [15:0] e_execr(
    input logic [2:0] s
  );
    return {4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, s};
  endfunction

  function automatic logic [15:0] e_execi(
    input logic [2:0] s
  );
    return {4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, s};
  endfunction

  function automatic logic [15:0] e_beq(input logic z);
    return {z, 3'b000, 1'b0, 2'b10, 2'b00, 2'b00,
            2'b00, 3'b001};
  endfunction

  task automatic test_reset();
    rst = 1'b1; opcode = 7'b1100011; funct3 = 3'b000;
    funct7_5 = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (ctl[15:12] !== 4'b0000) begin
      $display("FAIL reset_strobes got=%b exp=0000",
               ctl[15:12]);
      errs++;
    end
    vecs++;
    if (illegal_op !== 1'b0) begin
      $display("FAIL reset_illegal got=%b exp=0",
               illegal_op);
      errs++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if (ctl !== E_FETCH) begin
      $display("FAIL reset_fetch got=%h exp=%h",
               ctl, E_FETCH);
      errs++;
    end
    @(negedge clk); #1;
    vecs++;
    if (ctl !== E_DECODE) begin
      $display("FAIL reset_decode got=%h exp=%h",
               ctl, E_DECODE);
      errs++;
    end
    @(negedge clk); #1;
    vecs++;
    if (ctl !== e_beq(1'b0)) begin
      $display("FAIL reset_beq got=%h exp=%h",
               ctl, e_beq(1'b0));
      errs++;
    end
    @(negedge clk); #1;
    vecs++;
    if (ctl !== E_FETCH) begin
      $display("FAIL reset_refetch got=%h exp=%h",
               ctl, E_FETCH);
      errs++;
    end
  endtask

  task automatic test_load();
    logic [15:0] exp [6];
    exp = '{E_FETCH, E_DECODE, E_MEMADR_L,
            E_MEMREAD, E_MEMWB, E_FETCH};
    opcode = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      #1; vecs++;
      if (ctl !== exp[i]) begin
        $display("FAIL load c%0d got=%h exp=%h",
                 i, ctl, exp[i]);
        errs++;
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [15:0] exp [5];
    exp = '{E_FETCH, E_DECODE, E_MEMADR_S,
            E_MEMWRITE, E_FETCH};
    opcode = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      #1; vecs++;
      if (ctl !== exp[i]) begin
        $display("FAIL store c%0d got=%h exp=%h",
                 i, ctl, exp[i]);
        errs++;
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    logic [2:0]  f3  [3];
    logic        f7  [3];
    logic [2:0]  sel [3];
    logic [15:0] exp [5];
    f3  = '{3'b000, 3'b111, 3'b001};
    f7  = '{1'b1,   1'b0,   1'b0};
    sel = '{3'b001, 3'b011, 3'b000};
    for (int k = 0; k < 3; k++) begin
      opcode = 7'b0110011; funct3 = f3[k];
      funct7_5 = f7[k];
      exp = '{E_FETCH, E_DECODE, e_execr(sel[k]),
              E_ALUWB, E_FETCH};
      for (int i = 0; i < 5; i++) begin
        #1; vecs++;
        if (ctl !== exp[i]) begin
          $display("FAIL rtype%0d c%0d got=%h exp=%h",
                   k, i, ctl, exp[i]);
          errs++;
        end
        if (i < 4) @(negedge clk);
      end
    end
  endtask

  task automatic test_itype();
    logic [2:0]  f3  [3];
    logic [2:0]  sel [3];
    logic [15:0] exp [5];
    f3  = '{3'b000, 3'b010, 3'b110};
    sel = '{3'b000, 3'b100, 3'b010};
    for (int k = 0; k < 3; k++) begin
      opcode = 7'b0010011; funct3 = f3[k];
      funct7_5 = 1'b1;
      exp = '{E_FETCH, E_DECODE, e_execi(sel[k]),
              E_ALUWB, E_FETCH};
      for (int i = 0; i < 5; i++) begin
        #1; vecs++;
        if (ctl !== exp[i]) begin
          $display("FAIL itype%0d c%0d got=%h exp=%h",
                   k, i, ctl, exp[i]);
          errs++;
        end
        if (i < 4) @(negedge clk);
      end
    end
    funct7_5 = 1'b0;
  endtask

  task automatic test_beq();
    logic [15:0] exp [4];
    for (int z = 1; z >= 0; z--) begin
      opcode = 7'b1100011; funct3 = 3'b000;
      zero = z[0];
      exp = '{E_FETCH, E_DECODE, e_beq(z[0]), E_FETCH};
      for (int i = 0; i < 4; i++) begin
        #1; vecs++;
        if (ctl !== exp[i]) begin
          $display("FAIL beq_z%0d c%0d got=%h exp=%h",
                   z, i, ctl, exp[i]);
          errs++;
        end
        if (i < 3) @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [15:0] exp [5];
    exp = '{E_FETCH, E_DECODE, E_JAL,
            E_ALUWB, E_FETCH};
    opcode = 7'b1101111;
    for (int i = 0; i < 5; i++) begin
      #1; vecs++;
      if (ctl !== exp[i]) begin
        $display("FAIL jal c%0d got=%h exp=%h",
                 i, ctl, exp[i]);
        errs++;
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] exp [7];
    logic        ill [7];
    exp = '{E_FETCH, E_DECODE, E_FETCH, E_DECODE,
            e_execr(3'b010), E_ALUWB, E_FETCH};
    ill = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 7'b0000000; funct3 = 3'b110;
    funct7_5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) opcode = 7'b0110011;
      #1; vecs++;
      if (ctl !== exp[i]) begin
        $display("FAIL illegal c%0d got=%h exp=%h",
                 i, ctl, exp[i]);
        errs++;
      end
      vecs++;
      if (illegal_op !== ill[i]) begin
        $display("FAIL illegal_flag c%0d got=%b exp=%b",
                 i, illegal_op, ill[i]);
        errs++;
      end
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [3];
    exp = '{E_FETCH, E_DECODE, E_MEMADR_S};
    opcode = 7'b0100011;
    for (int i = 0; i < 3; i++) begin
      #1; vecs++;
      if (ctl !== exp[i]) begin
        $display("FAIL rstmid c%0d got=%h exp=%h",
                 i, ctl, exp[i]);
        errs++;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1; vecs++;
    if (ctl !== E_MEMREAD) begin
      $display("FAIL rstmid_memwrite got=%h exp=%h",
               ctl, E_MEMREAD);
      errs++;
    end
    @(negedge clk); #1; vecs++;
    if (ctl !== E_FETCH_RST) begin
      $display("FAIL rstmid_hold got=%h exp=%h",
               ctl, E_FETCH_RST);
      errs++;
    end
    rst = 1'b0;
    #1; vecs++;
    if (ctl !== E_FETCH) begin
      $display("FAIL rstmid_fetch got=%h exp=%h",
               ctl, E_FETCH);
      errs++;
    end
    vecs++;
    if (illegal_op !== 1'b0) begin
      $display("FAIL rstmid_illegal got=%b exp=0",
               illegal_op);
      errs++;
    end
    @(negedge clk); #1; vecs++;
    if (ctl !== E_DECODE) begin
      $display("FAIL rstmid_decode got=%h exp=%h",
               ctl, E_DECODE);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_rtype();
    test_itype();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed as: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 opcode  input  7  instruction[6:0] from instruction register.
REQ-003 funct3  input  3  instruction[14:12].
REQ-004 funct7_5  input  1  instruction[30].
REQ-005 zero  input  1  ALU Zero flag, same cycle.
REQ-006 pc_write  output  1  PC load strobe.
REQ-007 ir_write  output  1  instruction-register load strobe.
REQ-008 mem_write  output  1  data-memory write strobe.
REQ-009 reg_write  output  1  register-file write strobe.
REQ-010 adr_src  output  1  memory address: 0=PC, 1=ALUOut register.
REQ-011 alu_src_a  output  2  ALU A operand: 00=PC, 01=oldPC, 10=rs1 register.
REQ-012 alu_src_b  output  2  ALU B operand: 00=rs2 register, 01=immediate, 10=constant 4.
REQ-013 result_src  output  2  result mux: 00=ALUOut register, 01=data register, 10=ALU output.
REQ-014 imm_src  output  2  immediate format: 00=I, 01=S, 10=B, 11=J.
REQ-015 alu_sel  output  3  ALU select: 000 add, 001 sub, 010 or, 011 and, 100 slt.
REQ-016 illegal_op  output  1  sticky unsupported-opcode flag.

Function
REQ-017 The FSM SHALL have these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-018 Transitions SHALL be as follows:
- FETCH->DECODE.
- DECODE by opcode: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other->FETCH with illegal_op set.
- MEMADR->MEMREAD (load) or MEMWRITE (store).
- MEMREAD->MEMWB.
- EXECR, EXECI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-019 Outputs SHALL be a Moore function of state, except pc_write in BEQ, which is Mealy on zero.
REQ-020 FETCH SHALL drive: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_sel=add, result_src=10, pc_write=1.
REQ-021 DECODE SHALL drive: alu_src_a=01, alu_src_b=01, imm_src=10, alu_sel=add (branch target precompute).
REQ-022 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_sel=add, with imm_src=00 for loads and 01 for stores.
REQ-023 MEMREAD SHALL drive result_src=00, adr_src=1.
REQ-024 MEMWRITE SHALL drive result_src=00, adr_src=1, mem_write=1.
REQ-025 MEMWB SHALL drive result_src=01, reg_write=1.
REQ-026 ALUWB SHALL drive result_src=00, reg_write=1.
REQ-027 EXECR SHALL drive alu_src_a=10, alu_src_b=00, with alu_sel from the decoder.
REQ-028 EXECI SHALL drive alu_src_a=10, alu_src_b=01, imm_src=00, with alu_sel from the decoder.
REQ-029 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_sel=sub, result_src=00, and pc_write=zero.
REQ-030 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_sel=add, result_src=00, imm_src=11, pc_write=1.
REQ-031 The ALU decoder SHALL map funct3 as follows: 000->add, except R-type with funct7_5=1 ->sub; 010->slt; 110->or; 111->and; any other funct3->add.
REQ-032 Every strobe and field not listed for a state SHALL be 0.
REQ-033 Instruction latency SHALL be: load 5 cycles, store 4, R/I-type 4, beq 3, jal 4, illegal 2.
REQ-034 illegal_op SHALL be set in the DECODE cycle of an illegal opcode and held until reset.

Reset
REQ-035 On rst=1 at a clock edge, state SHALL become FETCH and illegal_op SHALL become 0.
REQ-036 While rst=1, pc_write, ir_write, mem_write and reg_write SHALL be forced to 0 combinationally.
REQ-037 The first cycle after rst deasserts SHALL be a FETCH with strobes active.
REQ-038 Reset asserted mid-instruction SHALL abort the instruction with no further write strobes.

Structure
REQ-039 A shared package ctrl_pkg SHALL hold the state enumeration, opcode constants, alu_sel encodings, and src-mux encodings.
REQ-040 The ALU decoding SHALL reside in a combinational sub-module alu_decoder (inputs funct3, funct7_5, is_rtype; output alu_sel).

Verification
REQ-041 Reset then release -> FETCH cycle with ir_write=1, pc_write=1; DECODE next.
REQ-042 opcode 0000011 -> 5-cycle sequence; reg_write=1 only in cycle 5 with result_src=01.
REQ-043 opcode 0110011, funct3=000, funct7_5=1 -> EXECR alu_sel=001; funct3=111 -> alu_sel=011.
REQ-044 opcode 1100011: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH.
REQ-045 opcode 0000000 -> DECODE->FETCH, illegal_op=1 held across later instructions until rst.
REQ-046 rst=1 during MEMWRITE -> mem_write=0 that cycle; FETCH next.
